// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first incrementer, zero-latency Mealy output
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic data,
    output logic out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // State is the pending carry into the current bit position
    typedef enum logic {
        CARRY0 = 1'b0,
        CARRY1 = 1'b1
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   next_cnt;
    logic            carry_eff;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CARRY1;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = bit_cnt;
        carry_eff  = reset ? 1'b1 : state;
        out        = data ^ carry_eff;

        // The word's final carry-out is dropped so all-ones wraps to zero
        if (bit_cnt == LAST) begin
            next_state = CARRY1;
            next_cnt   = '0;
        end else begin
            next_cnt = bit_cnt + 1'b1;
            case (state)
                CARRY1:  next_state = data ? CARRY1 : CARRY0;
                default: next_state = CARRY0;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed-vector bench for serial_adder (WIDTH 4 and 8)
module tb_serial_adder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic data = 1'b0;
    logic out;
    logic data8 = 1'b0;
    logic out8;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .out   (out)
    );

    serial_adder #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .data  (data8),
        .out   (out8)
    );

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one 4-bit word LSB first, capturing out mid-cycle for each bit
    task automatic send4(input logic [3:0] w, output logic [3:0] o);
        for (int i = 0; i < 4; i++) begin
            if (i != 0 || reset) @(negedge clk);
            if (i == 0 && reset) reset = 1'b0;
            data = w[i];
            #1;
            o[i] = out;
            @(posedge clk);
        end
    endtask

    task automatic send8(input logic [7:0] w, output logic [7:0] o);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            data8 = w[i];
            #1;
            o[i] = out8;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        data  = 1'b1;
        #1;
        vectors++;
        if (out !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_d1 got %b want 0", out);
        end
        data = 1'b0;
        #1;
        vectors++;
        if (out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_out_d0 got %b want 1", out);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_words();
        logic [3:0] o;
        logic [3:0] words [3] = '{4'd5, 4'd0, 4'd15};
        logic [3:0] exp   [3] = '{4'd6, 4'd1, 4'd0};
        for (int k = 0; k < 3; k++) begin
            pulse_reset();
            for (int i = 0; i < 4; i++) begin
                if (i != 0) @(negedge clk);
                data = words[k][i];
                #1;
                o[i] = out;
            end
            vectors++;
            if (o !== exp[k]) begin
                miscompares++;
                $display("FAIL word_%0d got %0d want %0d", words[k], o, exp[k]);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [3:0] o;
        logic [3:0] w;
        logic [3:0] e;
        for (int v = 0; v < 16; v++) begin
            w = 4'(v);
            e = 4'(v + 1);
            pulse_reset();
            for (int i = 0; i < 4; i++) begin
                if (i != 0) @(negedge clk);
                data = w[i];
                #1;
                o[i] = out;
            end
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL exhaustive_%0d got %0d want %0d", v, o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits = 8'b0111_0011;
        logic [7:0] o;
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            if (i != 0) @(negedge clk);
            data = bits[i];
            #1;
            o[i] = out;
        end
        vectors++;
        if (o[3:0] !== 4'd4) begin
            miscompares++;
            $display("FAIL b2b_word3 got %0d want 4", o[3:0]);
        end
        vectors++;
        if (o[7:4] !== 4'd8) begin
            miscompares++;
            $display("FAIL b2b_word7 got %0d want 8", o[7:4]);
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] o;
        logic [3:0] bits = 4'b0010;
        pulse_reset();
        data = 1'b1;
        @(negedge clk);
        data = 1'b1;
        // reset held two cycles with data=1: out must stay 0
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            reset = 1'b1;
            data  = 1'b1;
            #1;
            vectors++;
            if (out !== 1'b0) begin
                miscompares++;
                $display("FAIL held_reset_cyc%0d got %b want 0", c, out);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            data = bits[i];
            #1;
            o[i] = out;
        end
        vectors++;
        if (o !== 4'd3) begin
            miscompares++;
            $display("FAIL mid_reset_word got %0d want 3", o);
        end
        // reset coinciding with the last bit of a word
        pulse_reset();
        data = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bits = 4'd9;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            data = bits[i];
            #1;
            o[i] = out;
        end
        vectors++;
        if (o !== 4'd10) begin
            miscompares++;
            $display("FAIL reset_on_last_bit got %0d want 10", o);
        end
    endtask

    task automatic test_width8();
        logic [7:0] o;
        pulse_reset();
        data8 = 1'b1;
        #1;
        o[0] = out8;
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            data8 = 1'b1;
            #1;
            o[i] = out8;
        end
        vectors++;
        if (o !== 8'h00) begin
            miscompares++;
            $display("FAIL w8_ff got %02h want 00", o);
        end
        send8(8'h7F, o);
        vectors++;
        if (o !== 8'h80) begin
            miscompares++;
            $display("FAIL w8_7f got %02h want 80", o);
        end
        send8(8'h2B, o);
        vectors++;
        if (o !== 8'h2C) begin
            miscompares++;
            $display("FAIL w8_2b got %02h want 2c", o);
        end
    endtask

    initial begin
        test_reset();
        test_words();
        test_exhaustive();
        test_back_to_back();
        test_mid_reset();
        test_width8();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
